// File: rtl/tim1_ctrl.sv
// Timer control block: bus-mapped CR/SR/IER/PSC/ARR/CNT/EGR registers,
// run/halt sequencing, prescaler tick generation and update-event handling.
module tim1_ctrl #(
    parameter logic [15:0] PSC_RST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_sel,
    input  logic        bus_wr,
    input  logic [2:0]  bus_addr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_rvalid,
    input  logic [15:0] cnt_val,
    input  logic        cnt_ov,
    input  logic        cnt_uv,
    output logic        timer_en,
    output logic        ld_cnt,
    output logic        dir,
    output logic        dir_mode,
    output logic [15:0] arr,
    output logic [15:0] ld_data,
    output logic        irq
);

    localparam logic [2:0] ADDR_CR  = 3'd0;
    localparam logic [2:0] ADDR_SR  = 3'd1;
    localparam logic [2:0] ADDR_IER = 3'd2;
    localparam logic [2:0] ADDR_PSC = 3'd3;
    localparam logic [2:0] ADDR_ARR = 3'd4;
    localparam logic [2:0] ADDR_CNT = 3'd5;
    localparam logic [2:0] ADDR_EGR = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  cr;
    logic        uif;
    logic        uie;
    logic [15:0] psc;
    logic [15:0] psc_act;
    logic [15:0] prescaler;
    logic [15:0] arr_pre;
    logic        arr_wr_d;
    logic [15:0] rd_mux;

    logic        wr_cr;
    logic        wr_sr;
    logic        wr_ier;
    logic        wr_psc;
    logic        wr_arr;
    logic        wr_cnt;
    logic        ug_wr;
    logic        uev;
    logic        rd_req;

    logic        cr_cen;
    logic        cr_opm;
    logic        cr_arpe;

    assign cr_cen   = cr[0];
    assign dir      = cr[1];
    assign dir_mode = cr[2];
    assign cr_opm   = cr[3];
    assign cr_arpe  = cr[4];

    assign wr_cr  = bus_sel && bus_wr && (bus_addr == ADDR_CR);
    assign wr_sr  = bus_sel && bus_wr && (bus_addr == ADDR_SR);
    assign wr_ier = bus_sel && bus_wr && (bus_addr == ADDR_IER);
    assign wr_psc = bus_sel && bus_wr && (bus_addr == ADDR_PSC);
    assign wr_arr = bus_sel && bus_wr && (bus_addr == ADDR_ARR);
    assign wr_cnt = bus_sel && bus_wr && (bus_addr == ADDR_CNT);
    assign ug_wr  = bus_sel && bus_wr && (bus_addr == ADDR_EGR) && bus_wdata[0];
    assign rd_req = bus_sel && !bus_wr;

    // The tick is suppressed during a counter load so the fresh value is not advanced.
    assign timer_en = (state == RUN) && (prescaler == psc_act) && !ld_cnt;
    assign uev      = (timer_en && (cnt_ov || cnt_uv)) || ug_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cr_cen) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!cr_cen) begin
                    state_next = IDLE;
                end else if (uev && cr_opm) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-pulse mode drops CEN while halting so the timer stays stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cr  <= 5'd0;
            uie <= 1'b0;
            psc <= PSC_RST;
        end else begin
            if (wr_cr) begin
                cr <= bus_wdata[4:0];
            end
            if (state == HALT) begin
                cr[0] <= 1'b0;
            end
            if (wr_ier) begin
                uie <= bus_wdata[0];
            end
            if (wr_psc) begin
                psc <= bus_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uif <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (uev) begin
                uif <= 1'b1;
            end else if (wr_sr && bus_wdata[0]) begin
                uif <= 1'b0;
            end
            irq <= uif && uie;
        end
    end

    // With ARPE clear the preload reaches the active reload one cycle after the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_pre  <= 16'd0;
            arr      <= 16'd0;
            arr_wr_d <= 1'b0;
        end else begin
            arr_wr_d <= wr_arr;
            if (wr_arr) begin
                arr_pre <= bus_wdata;
            end
            if (cr_arpe ? uev : arr_wr_d) begin
                arr <= arr_pre;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt  <= 1'b0;
            ld_data <= 16'd0;
        end else begin
            ld_cnt <= wr_cnt || ug_wr;
            if (wr_cnt) begin
                ld_data <= bus_wdata;
            end else if (ug_wr) begin
                ld_data <= dir ? arr : 16'd0;
            end
        end
    end

    // A new PSC value only takes over at a wrap, so the running period is never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= 16'd0;
            psc_act   <= PSC_RST;
        end else if (state != RUN) begin
            prescaler <= 16'd0;
            psc_act   <= psc;
        end else if (wr_cnt || ug_wr) begin
            prescaler <= 16'd0;
        end else if (prescaler == psc_act) begin
            prescaler <= 16'd0;
            psc_act   <= psc;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    always_comb begin
        rd_mux = 16'd0;
        case (bus_addr)
            ADDR_CR:  rd_mux = {11'd0, cr};
            ADDR_SR:  rd_mux = {15'd0, uif};
            ADDR_IER: rd_mux = {15'd0, uie};
            ADDR_PSC: rd_mux = psc;
            ADDR_ARR: rd_mux = arr_pre;
            ADDR_CNT: rd_mux = cnt_val;
            default:  rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rvalid <= 1'b0;
            bus_rdata  <= 16'd0;
        end else begin
            bus_rvalid <= rd_req;
            bus_rdata  <= rd_req ? rd_mux : 16'd0;
        end
    end

endmodule

// File: tb/tb_tim1_ctrl.sv
// Self-checking bench for tim1_ctrl: directed timing scenarios plus a randomized
// register-file model for bus readback.
module tb_tim1_ctrl;

    localparam logic [15:0] PSC_INIT = 16'h0007;

    logic        clk;
    logic        rst;
    logic        bus_sel;
    logic        bus_wr;
    logic [2:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_rvalid;
    logic [15:0] cnt_val;
    logic        cnt_ov;
    logic        cnt_uv;
    logic        timer_en;
    logic        ld_cnt;
    logic        dir;
    logic        dir_mode;
    logic [15:0] arr;
    logic [15:0] ld_data;
    logic        irq;

    int tests_run;
    int tests_failed;

    tim1_ctrl #(.PSC_RST(PSC_INIT)) dut (
        .clk(clk), .rst(rst),
        .bus_sel(bus_sel), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .cnt_val(cnt_val), .cnt_ov(cnt_ov), .cnt_uv(cnt_uv),
        .timer_en(timer_en), .ld_cnt(ld_cnt), .dir(dir), .dir_mode(dir_mode),
        .arr(arr), .ld_data(ld_data), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
        cycle();
        bus_sel = 1'b0; bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic v, output logic [15:0] d);
        bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = a;
        cycle();
        bus_sel = 1'b0;
        v = bus_rvalid;
        d = bus_rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus_sel = 1'b0; bus_wr = 1'b0; cnt_ov = 1'b0; cnt_uv = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        logic v;
        logic [15:0] d;
        rst = 1'b1; bus_sel = 1'b0; bus_wr = 1'b0; bus_addr = 3'd0; bus_wdata = 16'd0;
        cnt_val = 16'h3C3C; cnt_ov = 1'b0; cnt_uv = 1'b0;
        cycle();
        cycle();
        tests_run++;
        if ({timer_en, ld_cnt, bus_rvalid, irq, dir, dir_mode} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 000000", {timer_en, ld_cnt, bus_rvalid, irq, dir, dir_mode});
        end
        tests_run++;
        if ({bus_rdata, arr, ld_data} !== 48'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h expected 0", {bus_rdata, arr, ld_data});
        end
        rst = 1'b0;
        cycle();
        bus_read(3'd3, v, d);
        tests_run++;
        if (v !== 1'b1 || d !== PSC_INIT) begin
            tests_failed++;
            $display("[TB] FAIL reset_psc_read: got v=%b d=%h expected v=1 d=%h", v, d, PSC_INIT);
        end
        cycle();
        tests_run++;
        if (bus_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rvalid_single: got %b expected 0", bus_rvalid);
        end
    endtask

    task automatic test_prescaler();
        logic [15:0] p;
        logic exp;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            p = (r == 0) ? 16'd2 : 16'($urandom_range(0, 4));
            bus_write(3'd0, 16'h0000);
            cycle();
            cycle();
            bus_write(3'd3, p);
            bus_write(3'd0, 16'h0001);
            // RUN cycle k = n-1 ticks when k mod (PSC+1) equals PSC
            for (int n = 0; n <= 12; n++) begin
                exp = (n >= 1) && (((n - 1) % (int'(p) + 1)) == int'(p));
                tests_run++;
                if (timer_en !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL psc_tick psc=%0d n=%0d: got %b expected %b", p, n, timer_en, exp);
                end
                cycle();
            end
        end
        bus_write(3'd0, 16'h0000);
        cycle();
        cycle();
        bus_write(3'd3, 16'd3);
        bus_write(3'd0, 16'h0001);
        cycle();
        cycle();
        bus_write(3'd3, 16'd0);
        for (int n = 3; n <= 6; n++) begin
            exp = (n != 3);
            tests_run++;
            if (timer_en !== exp) begin
                tests_failed++;
                $display("[TB] FAIL psc_at_wrap n=%0d: got %b expected %b", n, timer_en, exp);
            end
            cycle();
        end
    endtask

    task automatic test_update();
        logic v;
        logic [15:0] d;
        do_reset();
        bus_write(3'd4, 16'h00AB);
        tests_run++;
        if (arr !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL arr_direct_early: got %h expected 0000", arr);
        end
        cycle();
        tests_run++;
        if (arr !== 16'h00AB) begin
            tests_failed++;
            $display("[TB] FAIL arr_direct: got %h expected 00ab", arr);
        end
        do_reset();
        bus_write(3'd3, 16'd0);
        bus_write(3'd2, 16'd1);
        bus_write(3'd0, 16'h0010);
        bus_write(3'd4, 16'd5);
        cycle();
        cycle();
        tests_run++;
        if (arr !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL arr_preload_held: got %h expected 0000", arr);
        end
        bus_write(3'd0, 16'h0011);
        cycle();
        cnt_ov = 1'b1;
        tests_run++;
        if (timer_en !== 1'b1 || arr !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL uev_setup: got te=%b arr=%h expected te=1 arr=0000", timer_en, arr);
        end
        cycle();
        cnt_ov = 1'b0;
        tests_run++;
        if (arr !== 16'd5 || irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL uev_arr: got arr=%h irq=%b expected arr=0005 irq=0", arr, irq);
        end
        cycle();
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL uev_irq: got %b expected 1", irq);
        end
        // Clear request colliding with a fresh update event must leave UIF set
        cnt_ov = 1'b1;
        bus_write(3'd1, 16'h0001);
        cnt_ov = 1'b0;
        bus_read(3'd1, v, d);
        tests_run++;
        if (d !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL sr_clear_vs_uev: got %h expected 0001", d);
        end
        bus_write(3'd1, 16'h0001);
        bus_read(3'd1, v, d);
        tests_run++;
        if (d !== 16'd0 || irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sr_clear: got sr=%h irq=%b expected sr=0000 irq=0", d, irq);
        end
        bus_write(3'd5, 16'h1234);
        tests_run++;
        if (ld_cnt !== 1'b1 || ld_data !== 16'h1234 || timer_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cnt_load: got ld=%b data=%h te=%b expected ld=1 data=1234 te=0", ld_cnt, ld_data, timer_en);
        end
        cycle();
        tests_run++;
        if (ld_cnt !== 1'b0 || timer_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL cnt_load_after: got ld=%b te=%b expected ld=0 te=1", ld_cnt, timer_en);
        end
        bus_write(3'd6, 16'h0001);
        tests_run++;
        if (ld_cnt !== 1'b1 || ld_data !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL ug_up: got ld=%b data=%h expected ld=1 data=0000", ld_cnt, ld_data);
        end
        bus_read(3'd1, v, d);
        tests_run++;
        if (d !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL ug_uif: got %h expected 0001", d);
        end
        bus_write(3'd0, 16'h0017);
        tests_run++;
        if (dir !== 1'b1 || dir_mode !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL dir_bits: got dir=%b mode=%b expected 1 1", dir, dir_mode);
        end
        bus_write(3'd6, 16'h0001);
        tests_run++;
        if (ld_cnt !== 1'b1 || ld_data !== 16'd5) begin
            tests_failed++;
            $display("[TB] FAIL ug_down: got ld=%b data=%h expected ld=1 data=0005", ld_cnt, ld_data);
        end
        bus_write(3'd6, 16'h0000);
        tests_run++;
        if (ld_cnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ug_zero: got %b expected 0", ld_cnt);
        end
    endtask

    task automatic test_one_pulse();
        logic v;
        logic [15:0] d;
        do_reset();
        bus_write(3'd3, 16'd0);
        bus_write(3'd0, 16'h0009);
        cycle();
        cnt_uv = 1'b1;
        tests_run++;
        if (timer_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL opm_run: got %b expected 1", timer_en);
        end
        cycle();
        cnt_uv = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tests_run++;
            if (timer_en !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL opm_stopped n=%0d: got %b expected 0", n, timer_en);
            end
            cycle();
        end
        bus_read(3'd0, v, d);
        tests_run++;
        if (d !== 16'h0008) begin
            tests_failed++;
            $display("[TB] FAIL opm_cr: got %h expected 0008", d);
        end
    endtask

    task automatic test_reset_midrun();
        logic v;
        logic [15:0] d;
        do_reset();
        bus_write(3'd3, 16'd0);
        bus_write(3'd4, 16'hBEEF);
        bus_write(3'd2, 16'd1);
        bus_write(3'd5, 16'h5A5A);
        bus_write(3'd0, 16'h0001);
        bus_write(3'd6, 16'h0001);
        cycle();
        tests_run++;
        if (irq !== 1'b1 || arr !== 16'hBEEF) begin
            tests_failed++;
            $display("[TB] FAIL midrun_setup: got irq=%b arr=%h expected irq=1 arr=beef", irq, arr);
        end
        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = 3'd5; bus_wdata = 16'($urandom);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({timer_en, ld_cnt, bus_rvalid, irq} !== 4'b0 || {bus_rdata, arr, ld_data} !== 48'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_reset: got flags=%b data=%h expected 0", {timer_en, ld_cnt, bus_rvalid, irq}, {bus_rdata, arr, ld_data});
        end
        cycle();
        bus_sel = 1'b0; bus_wr = 1'b0; rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tests_run++;
            if ({ld_cnt, irq, timer_en} !== 3'b0) begin
                tests_failed++;
                $display("[TB] FAIL midrun_release n=%0d: got %b expected 000", n, {ld_cnt, irq, timer_en});
            end
            cycle();
        end
        bus_read(3'd1, v, d);
        tests_run++;
        if (d !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_uif: got %h expected 0000", d);
        end
    endtask

    task automatic test_random_regs();
        logic [4:0]  m_cr;
        logic        m_uie;
        logic [15:0] m_psc;
        logic [15:0] m_arr;
        logic [15:0] exp;
        logic [15:0] d;
        logic [2:0]  a;
        logic        v;
        do_reset();
        m_cr = 5'd0; m_uie = 1'b0; m_psc = PSC_INIT; m_arr = 16'd0;
        for (int i = 0; i < 40; i++) begin
            a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                d = 16'($urandom);
                if (a == 3'd6) d[0] = 1'b0;
                bus_write(a, d);
                case (a)
                    3'd0: m_cr = d[4:0];
                    3'd2: m_uie = d[0];
                    3'd3: m_psc = d;
                    3'd4: m_arr = d;
                    default: ;
                endcase
                tests_run++;
                if (bus_rvalid !== 1'b0 || dir !== m_cr[1] || dir_mode !== m_cr[2]) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_write a=%0d: got rv=%b dir=%b mode=%b expected 0 %b %b", a, bus_rvalid, dir, dir_mode, m_cr[1], m_cr[2]);
                end
            end else begin
                cnt_val = 16'($urandom);
                case (a)
                    3'd0: exp = {11'd0, m_cr};
                    3'd2: exp = {15'd0, m_uie};
                    3'd3: exp = m_psc;
                    3'd4: exp = m_arr;
                    3'd5: exp = cnt_val;
                    default: exp = 16'd0;
                endcase
                bus_read(a, v, d);
                tests_run++;
                if (v !== 1'b1 || d !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_read a=%0d: got v=%b d=%h expected v=1 d=%h", a, v, d, exp);
                end
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_prescaler();
        test_update();
        test_one_pulse();
        test_reset_midrun();
        test_random_regs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tim1_ctrl.md
TIM1_CTRL -- requirements
Module: tim1_ctrl

Interface
REQ-001 SHALL have parameter PSC_RST, default 16'h0000: prescaler register reset value.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports bus_sel input 1, bus_wr input 1, bus_addr input 3, bus_wdata input 16: single-cycle register access strobe, write flag, word address, write data.
REQ-005 SHALL have ports bus_rdata output 16, bus_rvalid output 1: read data and its valid flag, one cycle after a read strobe.
REQ-006 SHALL have ports cnt_val input 16, cnt_ov input 1, cnt_uv input 1: current count and overflow/underflow flags from the counter.
REQ-007 SHALL have ports timer_en output 1, ld_cnt output 1, dir output 1, dir_mode output 1, arr output 16, ld_data output 16: counter tick, load strobe, up/down, centre mode, active reload, load value.
REQ-008 SHALL have port irq  output  1  update interrupt, registered.

Function
REQ-009 SHALL decode registers: 0 CR{ARPE[4],OPM[3],DMODE[2],DIR[1],CEN[0]}, 1 SR{UIF[0]}, 2 IER{UIE[0]}, 3 PSC[15:0], 4 ARR preload[15:0], 5 CNT, 6 EGR{UG[0]}, 7 reserved (read 0, writes ignored).
REQ-010 SHALL return on bus_rdata, one cycle after sel&!wr, the addressed register, with CNT reading cnt_val and EGR reading 0; bus_rvalid high exactly that cycle.
REQ-011 SHALL run FSM IDLE->RUN when CEN=1, RUN->IDLE when CEN=0, RUN->HALT on update event with OPM=1, HALT->IDLE next cycle, clearing CEN in HALT.
REQ-012 SHALL run a 16-bit prescaler only in RUN, counting 0..PSC and wrapping to 0; timer_en high one cycle when prescaler==PSC (PSC=0 gives timer_en every RUN cycle).
REQ-013 SHALL hold prescaler at 0 and timer_en low in IDLE and HALT.
REQ-014 SHALL define update event UEV = (timer_en & (cnt_ov | cnt_uv)) | UG write.
REQ-015 SHALL copy ARR preload to active arr on UEV when ARPE=1, and on the cycle after any ARR write when ARPE=0.
REQ-016 SHALL set UIF on UEV; writing 1 to SR bit0 clears UIF; set wins over simultaneous clear.
REQ-017 SHALL drive irq = registered (UIF & UIE), one cycle after UIF changes.
REQ-018 SHALL, on CNT write, drive ld_data=wdata and pulse ld_cnt for one cycle on the next cycle, suppress timer_en that cycle, and reset prescaler to 0.
REQ-019 SHALL, on UG write, reset prescaler, pulse ld_cnt with ld_data=0 if DIR=0 else active arr, and assert UEV.
REQ-020 SHALL let a CNT write win over a same-cycle UG; the UG flag still sets UIF.
REQ-021 SHALL drive dir=CR.DIR and dir_mode=CR.DMODE combinationally from CR.
REQ-022 SHALL treat writes to PSC as effective at the next prescaler wrap, not immediately.

Reset
REQ-023 SHALL, on rst, clear CR, SR, IER, ARR preload, active arr, ld_data and prescaler, load PSC with PSC_RST, enter IDLE, and drive timer_en, ld_cnt, bus_rvalid, bus_rdata and irq low/0.
REQ-024 SHALL abort in-progress operation on rst mid-run with no pending ld_cnt or UIF surviving deassertion.

Verification
REQ-025 SHALL verify PSC=2, CEN=1 -> timer_en high every 3rd cycle starting 3 cycles after RUN entry.
REQ-026 SHALL verify ARR preload=5, ARPE=1, cnt_ov with timer_en -> arr changes 0->5 next cycle, UIF=1, irq=1 one cycle later with UIE=1.
REQ-027 SHALL verify OPM=1, cnt_ov with timer_en -> HALT, then IDLE, with CR.CEN read back 0 and timer_en stuck low.
REQ-028 SHALL verify CNT write 16'h1234 -> ld_cnt one-cycle pulse, ld_data=16'h1234, no timer_en that cycle.
REQ-029 SHALL verify SR clear write coincident with UEV -> UIF remains 1.
REQ-030 SHALL verify rst asserted during RUN with pending CNT write -> all outputs 0, no ld_cnt after release.
